// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async FIFO. Pops DATA_WIDTH-bit
// entries (registered rd_data, one cycle latency) and packs PACK_NUM of them,
// first entry in the least significant slot, into one word presented on a
// valid/ready stream. All pop timing is owned here, so the FIFO is never
// over-read and no popped entry is dropped.
// Optional build macro PACK_PARTIAL_FLUSH_EN: a partial word is flushed after
// TIMEOUT idle cycles, with out_keep marking the filled slots.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_NUM   = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_empty,
   output logic                           o_rd_en,
   input  logic [DATA_WIDTH-1:0]          i_rd_data,
   output logic                           o_out_valid,
   input  logic                           i_out_ready,
   output logic [DATA_WIDTH*PACK_NUM-1:0] o_out_data,
   output logic [PACK_NUM-1:0]            o_out_keep
);

   localparam int            CW        = $clog2(PACK_NUM) + 1;
   localparam int            WW        = DATA_WIDTH * PACK_NUM;
   localparam logic [CW-1:0] LAST_SLOT = CW'(PACK_NUM - 1);
   localparam logic [CW-1:0] N_SLOTS   = CW'(PACK_NUM);

   logic [CW-1:0]         r_cnt;
   logic                  r_pend;
   logic [DATA_WIDTH-1:0] r_acc [PACK_NUM];
   logic [WW-1:0]         r_out_data;
   logic [PACK_NUM-1:0]   r_out_keep;
   logic                  r_out_valid;

   logic [CW-1:0]         w_sum;
   logic [CW-1:0]         w_pos;
   logic                  w_last_pop;
   logic                  w_hold;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_flush;
   logic                  w_load;
   logic [WW-1:0]         w_word;
   logic [PACK_NUM-1:0]   w_part_keep;

   // Slot the next pop will land in: captured entries plus the one in flight.
   assign w_sum      = r_cnt + {{(CW-1){1'b0}}, r_pend};
   assign w_pos      = (w_sum == N_SLOTS) ? '0 : w_sum;
   assign w_last_pop = (w_pos == LAST_SLOT);
   assign w_hold     = r_out_valid && !i_out_ready;

   // The pop that completes a word is withheld while the output register is
   // stuck, so the completing capture always finds the register free.
   assign o_rd_en = !rst && !i_empty && !(w_last_pop && w_hold) && !w_flush;
   assign w_pop   = o_rd_en;

   assign w_full = r_pend && (r_cnt == LAST_SLOT);
   assign w_load = w_full || w_flush;

   genvar gi;
   generate
      for (gi = 0; gi < PACK_NUM; gi++) begin : g_slot
         assign w_part_keep[gi] = (CW'(gi) < r_cnt);
         // Word being loaded: the live read data fills the completing slot,
         // filled slots come from the accumulator, the rest read as zero.
         assign w_word[gi*DATA_WIDTH +: DATA_WIDTH] =
            (r_pend && (r_cnt == CW'(gi))) ? i_rd_data :
            (w_part_keep[gi] ? r_acc[gi] : '0);
      end
   endgenerate

`ifdef PACK_PARTIAL_FLUSH_EN
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
   logic [7:0] r_idle;

   assign w_flush = (r_idle == TIMEOUT_C) && (r_cnt != '0) && !r_pend && !w_hold;

   // Idle counter: counts starved cycles with a partial word, saturating at TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle <= '0;
      end else if (w_pop || r_pend || w_flush) begin
         r_idle <= '0;
      end else if ((r_cnt != '0) && i_empty && (r_idle != TIMEOUT_C)) begin
         r_idle <= r_idle + 8'd1;
      end
   end
`else
   assign w_flush = 1'b0;
`endif

   // Accumulator: the in-flight entry is written into slot cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < PACK_NUM; k++) begin
            r_acc[k] <= '0;
         end
      end else if (r_pend) begin
         for (int k = 0; k < PACK_NUM; k++) begin
            if (r_cnt == CW'(k)) begin
               r_acc[k] <= i_rd_data;
            end
         end
      end
   end

   // Read-latency flag, slot counter and output register with handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend      <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
      end else begin
         r_pend <= w_pop;
         if (w_load) begin
            r_cnt <= '0;
         end else if (r_pend) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_keep  <= w_full ? '1 : w_part_keep;
         end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_keep  = r_out_keep;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: behavioural FIFO model feeding the DUT,
// scoreboard of expected packed words, table of streaming scenarios plus
// hand-written backpressure, reset and partial-word sequences.
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PN = 4;
   localparam int WW = DW * PN;

   logic          clk         = 1'b0;
   logic          rst         = 1'b1;
   logic          i_empty     = 1'b1;
   logic          o_rd_en;
   logic [DW-1:0] i_rd_data   = '0;
   logic          o_out_valid;
   logic          i_out_ready = 1'b1;
   logic [WW-1:0] o_out_data;
   logic [PN-1:0] o_out_keep;

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_empty    (i_empty),
      .o_rd_en    (o_rd_en),
      .i_rd_data  (i_rd_data),
      .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready),
      .o_out_data (o_out_data),
      .o_out_keep (o_out_keep)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            n;
      logic [7:0]    base;
      logic [7:0]    stride;
      bit            toggle;
      int            exp_words;
      logic [WW-1:0] exp_first;
   } vec_t;

   vec_t              vecs[4];
   logic [DW-1:0]     fifo_q[$];
   logic [PN+WW-1:0]  sb_q[$];
   logic [WW-1:0]     part_data      = '0;
   logic [WW-1:0]     first_word     = '0;
   int                part_n         = 0;
   int                checks         = 0;
   int                passes         = 0;
   int                cyc            = 0;
   int                words_seen     = 0;
   int                pops_seen      = 0;
   int                valid_cycles   = 0;
   int                first_pop_cyc  = -1;
   int                first_valid_cyc = -1;
   int                prev_hs_cyc    = -1;
   int                gap_bad        = 0;
   int                ready_low_left = 0;
   bit                pop_now        = 1'b0;
   bit                force_empty    = 1'b0;
   bit                toggle_en      = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic new_scenario();
      words_seen      = 0;
      pops_seen       = 0;
      valid_cycles    = 0;
      first_pop_cyc   = -1;
      first_valid_cyc = -1;
      prev_hs_cyc     = -1;
      gap_bad         = 0;
   endtask

   task automatic sample_pop();
      pop_now = o_rd_en && !i_empty;
      if (pop_now) begin
         pops_seen++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
   endtask

   // After loading the FIFO model between clock edges.
   task automatic refresh();
      i_empty = force_empty || (fifo_q.size() == 0);
      #1;
      sample_pop();
   endtask

   // One clock cycle: complete the previous pop, drive inputs, check outputs.
   task automatic step();
      logic [PN+WW-1:0] exp_w;
      @(posedge clk);
      #1;
      if (pop_now) begin
         if (fifo_q.size() == 0) begin
            check("fifo_level_at_pop", fifo_q.size(), 1);
         end else begin
            i_rd_data = fifo_q.pop_front();
            part_data[part_n*DW +: DW] = i_rd_data;
            part_n++;
            if (part_n == PN) begin
               sb_q.push_back({{PN{1'b1}}, part_data});
               part_n    = 0;
               part_data = '0;
            end
         end
      end
      force_empty = toggle_en ? !force_empty : 1'b0;
      i_empty     = force_empty || (fifo_q.size() == 0);
      i_out_ready = (ready_low_left == 0);
      if (ready_low_left > 0) ready_low_left--;
      #1;
      cyc++;
      check("rd_en_while_empty", {63'd0, o_rd_en && i_empty}, 64'd0);
      if (o_out_valid) begin
         valid_cycles++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (o_out_valid && i_out_ready) begin
         if (sb_q.size() == 0) begin
            check("word_without_expectation", sb_q.size(), 1);
         end else begin
            exp_w = sb_q.pop_front();
            $display("word %0d: data=%h keep=%b", words_seen, o_out_data, o_out_keep);
            check("out_data", o_out_data, exp_w[WW-1:0]);
            check("out_keep", o_out_keep, exp_w[PN+WW-1:WW]);
         end
         if (words_seen == 0) first_word = o_out_data;
         words_seen++;
         if (prev_hs_cyc >= 0 && (cyc - prev_hs_cyc) != PN) gap_bad++;
         prev_hs_cyc = cyc;
      end
      sample_pop();
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", o_out_valid, 0);
      check("mid_rst_cnt", dut.r_cnt, 0);
      check("mid_rst_rd_en", o_rd_en, 0);
      part_n    = 0;
      part_data = '0;
      pop_now   = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      sample_pop();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] val;
      vecs[0] = '{4,  8'h11, 8'h11, 1'b0, 1, 32'h44332211};
      vecs[1] = '{12, 8'h01, 8'h01, 1'b0, 3, 32'h04030201};
      vecs[2] = '{16, 8'h80, 8'h03, 1'b1, 4, 32'h89868380};
      vecs[3] = '{8,  8'hF0, 8'h01, 1'b0, 2, 32'hF3F2F1F0};

      // Reset state, with empty low so a leaking rd_en would show.
      i_empty = 1'b0;
      #2;
      check("rst_rd_en", o_rd_en, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_out_keep", o_out_keep, 0);
      i_empty = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;

      // Table-driven streaming scenarios.
      for (int v = 0; v < 4; v++) begin
         new_scenario();
         toggle_en = vecs[v].toggle;
         val = vecs[v].base;
         for (int k = 0; k < vecs[v].n; k++) begin
            fifo_q.push_back(val);
            val = val + vecs[v].stride;
         end
         refresh();
         for (int k = 0; k < 400 && words_seen < vecs[v].exp_words; k++) step();
         toggle_en = 1'b0;
         repeat (12) step();
         check($sformatf("v%0d_words", v), words_seen, vecs[v].exp_words);
         check($sformatf("v%0d_first_word", v), first_word, vecs[v].exp_first);
         check($sformatf("v%0d_sb_left", v), sb_q.size(), 0);
         check($sformatf("v%0d_fifo_left", v), fifo_q.size(), 0);
         if (!vecs[v].toggle) begin
            check($sformatf("v%0d_gap", v), gap_bad, 0);
            check($sformatf("v%0d_valid_cycles", v), valid_cycles, vecs[v].exp_words);
            check($sformatf("v%0d_latency", v), first_valid_cyc - first_pop_cyc, PN + 1);
         end
      end

      // Backpressure: first word held, exactly PN-1 further pops, then stall.
      new_scenario();
      for (int k = 1; k <= 8; k++) fifo_q.push_back(8'(k));
      ready_low_left = 20;
      i_out_ready    = 1'b0;
      refresh();
      repeat (10) step();
      check("bp_held_data_mid", o_out_data, 32'h04030201);
      repeat (10) step();
      check("bp_pops", pops_seen, 7);
      check("bp_rd_en_stalled", o_rd_en, 0);
      check("bp_valid_held", o_out_valid, 1);
      check("bp_held_data", o_out_data, 32'h04030201);
      check("bp_held_keep", o_out_keep, 4'hF);
      for (int k = 0; k < 100 && words_seen < 2; k++) step();
      repeat (8) step();
      check("bp_words", words_seen, 2);
      check("bp_sb_left", sb_q.size(), 0);

      // Reset with two entries captured; the next four must form a clean word.
      new_scenario();
      fifo_q.push_back(8'h55);
      fifo_q.push_back(8'h66);
      refresh();
      for (int k = 0; k < 20 && dut.r_cnt != 2; k++) step();
      check("pre_rst_cnt", dut.r_cnt, 2);
      do_reset();
      for (int k = 1; k <= 4; k++) fifo_q.push_back(8'(8'h70 + k));
      refresh();
      for (int k = 0; k < 50 && words_seen < 1; k++) step();
      repeat (6) step();
      check("post_rst_words", words_seen, 1);
      check("post_rst_word", first_word, 32'h74737271);
      check("post_rst_sb_left", sb_q.size(), 0);

      // Partial word followed by a long idle stretch.
      new_scenario();
      fifo_q.push_back(8'hAA);
      fifo_q.push_back(8'hBB);
      refresh();
`ifdef PACK_PARTIAL_FLUSH_EN
      sb_q.push_back({4'b0011, 32'h0000BBAA});
      for (int k = 0; k < 60 && words_seen < 1; k++) step();
      part_n    = 0;
      part_data = '0;
      repeat (4) step();
      check("flush_words", words_seen, 1);
      check("flush_cnt_cleared", dut.r_cnt, 0);
      check("flush_sb_left", sb_q.size(), 0);
`else
      repeat (40) step();
      check("no_flush_words", words_seen, 0);
      check("no_flush_valid", o_out_valid, 0);
      check("no_flush_cnt", dut.r_cnt, 2);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
